// File: rtl/mc_pack_seq_pkg.sv
// -----------------------------------------------------------------------------
// mc_pack_seq_pkg
// Shared definitions for the narrow-memory beat sequencer:
//   - bus width codes (MC_BW_*)
//   - sequencer state encoding (mc_ps_e, 3-bit)
//   - registered output bundle (mc_out_t)
//   - helpers mapping bus width / beat index to last-beat index and address LSBs
// -----------------------------------------------------------------------------
package mc_pack_seq_pkg;

    // Memory data-bus width codes; code 3 behaves like 32-bit.
    localparam logic [1:0] MC_BW_8  = 2'h0;
    localparam logic [1:0] MC_BW_16 = 2'h1;
    localparam logic [1:0] MC_BW_32 = 2'h2;

    typedef enum logic [2:0] {
        MC_PS_IDLE  = 3'd0,
        MC_PS_SETUP = 3'd1,
        MC_PS_WAIT  = 3'd2,
        MC_PS_LATCH = 3'd3,
        MC_PS_DONE  = 3'd4
    } mc_ps_e;

    // Everything the sequencer drives off-block, registered as one bundle.
    typedef struct packed {
        logic       busy;
        logic       mem_cs;
        logic       mem_oe;
        logic       mem_we;
        logic [1:0] adr_lsb;
        logic [1:0] wr_lane;
        logic [2:0] pack_le;
        logic       dv;
        logic       done;
    } mc_out_t;

    // Index of the final beat: 3 for 8-bit, 1 for 16-bit, 0 for 32-bit.
    function automatic logic [1:0] mc_last_beat(input logic [1:0] bw);
        logic [1:0] last;
        case (bw)
            MC_BW_8:  last = 2'd3;
            MC_BW_16: last = 2'd1;
            default:  last = 2'd0;
        endcase
        return last;
    endfunction

    // Byte offset of a beat inside the 32-bit word.
    function automatic logic [1:0] mc_beat_lsb(input logic [1:0] bw,
                                               input logic [1:0] beat);
        logic [1:0] lsb;
        case (bw)
            MC_BW_8:  lsb = beat;
            MC_BW_16: lsb = {beat[0], 1'b0};
            default:  lsb = 2'd0;
        endcase
        return lsb;
    endfunction

endpackage

// File: rtl/mc_pack_seq_ws_cnt.sv
// -----------------------------------------------------------------------------
// mc_ws_cnt
// Loadable down-counter with a zero flag. Saturates at zero (never wraps).
// Used for the per-beat wait-state count and for the optional ready timeout.
//
// Ports:
//   clk_i       clock
//   rst_ni      synchronous active-low reset (clears the count)
//   load_i      load load_val_i (has priority over dec_i)
//   load_val_i  value to load
//   dec_i       decrement by one unless already zero
//   zero_o      count is zero
// -----------------------------------------------------------------------------
module mc_ws_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: default assignment first so every path writes cnt_d; otherwise a latch is inferred.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mc_pack_seq.sv
// -----------------------------------------------------------------------------
// mc_pack_seq
// Beat sequencer for narrow asynchronous memories. Splits one 32-bit access
// into 4 (8-bit bus), 2 (16-bit) or 1 (32-bit) memory beats. Each beat runs
// SETUP -> WAIT (twait wait states, then mem_rdy) -> LATCH. Reads pulse the
// pack latch enables for every beat but the last and dv on the last; writes
// select the lane for each beat. A DONE cycle closes the access.
//
// Optional feature: define MC_PACK_TIMEOUT_EN to build a ready timeout. Once the
// wait states have elapsed, TO_CYC cycles without mem_rdy pulse err and drop
// the access without done/dv. Without the macro err is constant 0 and WAIT
// holds until mem_rdy.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   start      begin an access (sampled only in IDLE)
//   abort      cancel the access (overrides start in IDLE)
//   we         1 = write, 0 = read (latched at start)
//   bus_width  0 = 8-bit, 1 = 16-bit, 2/3 = 32-bit (latched at start)
//   twait      wait states per beat (latched at start)
//   mem_rdy    synchronised memory ready
//   busy       high whenever not IDLE
//   mem_cs     chip select (SETUP/WAIT/LATCH)
//   mem_oe     output enable, reads, same window as mem_cs
//   mem_we     write strobe, writes, WAIT only
//   adr_lsb    byte address offset of the current beat
//   wr_lane    write lane select for the current beat
//   pack_le0..2 read pack latch enables
//   dv         read word complete (1-cycle pulse)
//   done       access complete (1-cycle pulse)
//   err        ready timeout (1-cycle pulse)
// -----------------------------------------------------------------------------
module mc_pack_seq
    import mc_pack_seq_pkg::*;
#(
    parameter int WAIT_W = 4,
    parameter int TO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              we,
    input  logic [1:0]        bus_width,
    input  logic [WAIT_W-1:0] twait,
    input  logic              mem_rdy,
    output logic              busy,
    output logic              mem_cs,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [1:0]        adr_lsb,
    output logic [1:0]        wr_lane,
    output logic              pack_le0,
    output logic              pack_le1,
    output logic              pack_le2,
    output logic              dv,
    output logic              done,
    output logic              err
);

    mc_ps_e            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic              we_q, we_d;
    logic [1:0]        bw_q, bw_d;
    logic [WAIT_W-1:0] twait_q, twait_d;
    mc_out_t           out_q, out_d;
    logic              err_q, err_d;

    logic              last;
    logic              ws_load, ws_dec, ws_zero;

    // Wait-state counter: loaded in SETUP, counts down through WAIT.
    mc_ws_cnt #(.W(WAIT_W)) u_ws_cnt (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (ws_load),
        .load_val_i (twait_q),
        .dec_i      (ws_dec),
        .zero_o     (ws_zero)
    );

`ifdef MC_PACK_TIMEOUT_EN
    logic to_load, to_dec, to_zero;

    // Timeout counter loaded with TO_CYC-1 so that the cycle in which it is
    // decremented from zero is the TO_CYC-th stalled cycle; err appears in
    // the following cycle together with the return to IDLE.
    mc_ws_cnt #(.W(8)) u_to_cnt (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (to_load),
        .load_val_i (8'(TO_CYC - 1)),
        .dec_i      (to_dec),
        .zero_o     (to_zero)
    );
`else
    // TO_CYC only matters when the timeout counter is built.
    logic unused_to_cyc;
    assign unused_to_cyc = ^TO_CYC;
`endif

    assign last = (beat_q == mc_last_beat(bw_q));

    // Output decode for a given (next) state; registered so outputs are glitch-free.
    function automatic mc_out_t mc_decode(input mc_ps_e     st,
                                          input logic [1:0] beat,
                                          input logic       wr,
                                          input logic [1:0] bw);
        mc_out_t o;
        logic    lst;
        o        = '0;
        lst      = (beat == mc_last_beat(bw));
        o.busy   = (st != MC_PS_IDLE);
        o.mem_cs = st inside {MC_PS_SETUP, MC_PS_WAIT, MC_PS_LATCH};
        o.mem_oe = o.mem_cs && !wr;
        o.mem_we = (st == MC_PS_WAIT) && wr;
        // Beat offsets are only meaningful while an access is in flight.
        if (o.busy) begin
            o.adr_lsb = mc_beat_lsb(bw, beat);
            if (wr) begin
                o.wr_lane = o.adr_lsb;
            end
        end
        if ((st == MC_PS_LATCH) && !wr) begin
            if (lst) begin
                o.dv = 1'b1;
            end else begin
                case (beat)
                    2'd0:    o.pack_le[0] = 1'b1;
                    2'd1:    o.pack_le[1] = 1'b1;
                    2'd2:    o.pack_le[2] = 1'b1;
                    default: o.pack_le    = '0;
                endcase
            end
        end
        o.done = (st == MC_PS_DONE);
        return o;
    endfunction

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        we_d    = we_q;
        bw_d    = bw_q;
        twait_d = twait_q;
        err_d   = 1'b0;
        ws_load = 1'b0;
        ws_dec  = 1'b0;
`ifdef MC_PACK_TIMEOUT_EN
        to_load = 1'b0;
        to_dec  = 1'b0;
`endif
        if ((state_q != MC_PS_IDLE) && abort) begin
            state_d = MC_PS_IDLE;
            beat_d  = 2'd0;
        end else begin
            case (state_q)
                MC_PS_IDLE: begin
                    if (start && !abort) begin
                        state_d = MC_PS_SETUP;
                        we_d    = we;
                        bw_d    = bus_width;
                        twait_d = twait;
                        beat_d  = 2'd0;
                    end
                end
                MC_PS_SETUP: begin
                    ws_load = 1'b1;
`ifdef MC_PACK_TIMEOUT_EN
                    to_load = 1'b1;
`endif
                    state_d = MC_PS_WAIT;
                end
                MC_PS_WAIT: begin
                    ws_dec = !ws_zero;
                    // mem_rdy only counts once the wait states have run out.
                    if (ws_zero && mem_rdy) begin
                        state_d = MC_PS_LATCH;
                    end
`ifdef MC_PACK_TIMEOUT_EN
                    else if (ws_zero) begin
                        to_dec = 1'b1;
                        if (to_zero) begin
                            state_d = MC_PS_IDLE;
                            beat_d  = 2'd0;
                            err_d   = 1'b1;
                        end
                    end
`endif
                end
                MC_PS_LATCH: begin
                    if (last) begin
                        state_d = MC_PS_DONE;
                    end else begin
                        beat_d  = beat_q + 2'd1;
                        state_d = MC_PS_SETUP;
                    end
                end
                MC_PS_DONE: begin
                    state_d = MC_PS_IDLE;
                end
                default: begin
                    state_d = MC_PS_IDLE;
                end
            endcase
        end
        out_d = mc_decode(state_d, beat_d, we_d, bw_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= MC_PS_IDLE;
            beat_q  <= 2'd0;
            we_q    <= 1'b0;
            bw_q    <= 2'd0;
            twait_q <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            we_q    <= we_d;
            bw_q    <= bw_d;
            twait_q <= twait_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign busy     = out_q.busy;
    assign mem_cs   = out_q.mem_cs;
    assign mem_oe   = out_q.mem_oe;
    assign mem_we   = out_q.mem_we;
    assign adr_lsb  = out_q.adr_lsb;
    assign wr_lane  = out_q.wr_lane;
    assign pack_le0 = out_q.pack_le[0];
    assign pack_le1 = out_q.pack_le[1];
    assign pack_le2 = out_q.pack_le[2];
    assign dv       = out_q.dv;
    assign done     = out_q.done;
    assign err      = err_q;

endmodule

// File: tb/tb_mc_pack_seq.sv
// -----------------------------------------------------------------------------
// tb_mc_pack_seq
// Directed bench for mc_pack_seq. Each access launched pushes its expected
// pulse events (pack_le/dv/done/err with cycle and address offset) into a
// queue; a monitor on the falling edge pops and compares whenever the DUT
// shows any pulse. Level checks cover reset, idle, strobes and abort/reset.
// -----------------------------------------------------------------------------
module tb_mc_pack_seq;
    import mc_pack_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, abort, we, mem_rdy;
    logic [1:0] bus_width;
    logic [3:0] twait;
    logic       busy, mem_cs, mem_oe, mem_we, pack_le0, pack_le1, pack_le2, dv, done, err;
    logic [1:0] adr_lsb, wr_lane;

    mc_pack_seq #(.WAIT_W(4), .TO_CYC(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .we(we),
        .bus_width(bus_width), .twait(twait), .mem_rdy(mem_rdy),
        .busy(busy), .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
        .adr_lsb(adr_lsb), .wr_lane(wr_lane), .pack_le0(pack_le0),
        .pack_le1(pack_le1), .pack_le2(pack_le2), .dv(dv), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pulse kinds: {le0, le1, le2, dv, done, err}
    localparam logic [5:0] K_LE0  = 6'b100000;
    localparam logic [5:0] K_LE1  = 6'b010000;
    localparam logic [5:0] K_LE2  = 6'b001000;
    localparam logic [5:0] K_DV   = 6'b000100;
    localparam logic [5:0] K_DONE = 6'b000010;
    localparam logic [5:0] K_ERR  = 6'b000001;

    typedef struct {
        int         cyc;
        logic [5:0] kind;
        logic       chk_adr;
        logic [1:0] adr;
    } ev_t;

    ev_t exp_q[$];

    task automatic push_ev(input int c, input logic [5:0] k, input logic ca, input logic [1:0] a);
        ev_t e;
        e.cyc = c; e.kind = k; e.chk_adr = ca; e.adr = a;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every observed pulse against the next expected event.
    ev_t        mon_e;
    logic [5:0] mon_k;
    always @(negedge clk) begin
        mon_k = {pack_le0, pack_le1, pack_le2, dv, done, err};
        if (mon_k != 6'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(mon_k), 32'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", 32'(mon_k), 32'(mon_e.kind));
                check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
                if (mon_e.chk_adr) check("pulse_adr_lsb", 32'(adr_lsb), 32'(mon_e.adr));
            end
        end
    end

    // All outputs as one vector: {busy,cs,oe,we,adr[1:0],lane[1:0],le0,le1,le2,dv,done,err}
    logic [13:0] outs;
    assign outs = {busy, mem_cs, mem_oe, mem_we, adr_lsb, wr_lane,
                   pack_le0, pack_le1, pack_le2, dv, done, err};
    localparam logic [13:0] O_IDLE = 14'b0;
    localparam logic [13:0] O_RD   = {4'b1110, 10'b0};
    localparam logic [13:0] O_WR   = {4'b1100, 10'b0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one cycle; t0 is the cycle in which start is sampled.
    task automatic launch(output int t0, input logic w, input logic [1:0] bw, input logic [3:0] tw);
        start = 1'b1; we = w; bus_width = bw; twait = tw;
        t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int t0, t1;

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; we = 1'b0;
        bus_width = 2'd0; twait = 4'd0; mem_rdy = 1'b1;
        repeat (3) tick();
        check("reset_outs", 32'(outs), 32'(O_IDLE));
        rst = 1'b1;
        tick();

        // 8-bit read, twait 2: 4 beats of 5 cycles.
        launch(t0, 1'b0, MC_BW_8, 4'd2);
        push_ev(t0 + 5,  K_LE0,  1'b1, 2'd0);
        push_ev(t0 + 10, K_LE1,  1'b1, 2'd1);
        push_ev(t0 + 15, K_LE2,  1'b1, 2'd2);
        push_ev(t0 + 20, K_DV,   1'b1, 2'd3);
        push_ev(t0 + 21, K_DONE, 1'b0, 2'd0);
        check("rd8_setup_outs", 32'(outs), 32'(O_RD));
        repeat (21) tick();
        check("rd8_idle_after_done", 32'(outs), 32'(O_IDLE));

        // 16-bit read, twait 0, launched back-to-back; a start while busy is ignored.
        launch(t0, 1'b0, MC_BW_16, 4'd0);
        push_ev(t0 + 3, K_LE0,  1'b1, 2'd0);
        push_ev(t0 + 6, K_DV,   1'b1, 2'd2);
        push_ev(t0 + 7, K_DONE, 1'b0, 2'd0);
        tick();
        start = 1'b1; bus_width = MC_BW_8;
        tick();
        start = 1'b0;
        repeat (5) tick();

        // 32-bit write, twait 1, mem_rdy held low until cycle 6.
        mem_rdy = 1'b0;
        launch(t0, 1'b1, MC_BW_32, 4'd1);
        push_ev(t0 + 8, K_DONE, 1'b0, 2'd0);
        check("wr32_setup_outs", 32'(outs), 32'(O_WR));
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) tick();
            if (c == 6) mem_rdy = 1'b1;
            check($sformatf("wr32_mem_we_c%0d", c), 32'(mem_we), 32'((c >= 2 && c <= 6) ? 1 : 0));
            if (c == 2) check("wr32_wr_lane", 32'(wr_lane), 32'(0));
        end
        tick();

        // 8-bit read aborted in cycle 7, restarted in cycle 9.
        launch(t0, 1'b0, MC_BW_8, 4'd2);
        push_ev(t0 + 5, K_LE0, 1'b1, 2'd0);
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_outs_zero", 32'(outs), 32'(O_IDLE));
        tick();
        launch(t1, 1'b0, MC_BW_8, 4'd0);
        check("restart_cycle", 32'(t1), 32'(t0 + 9));
        push_ev(t1 + 3,  K_LE0,  1'b1, 2'd0);
        push_ev(t1 + 6,  K_LE1,  1'b1, 2'd1);
        push_ev(t1 + 9,  K_LE2,  1'b1, 2'd2);
        push_ev(t1 + 12, K_DV,   1'b1, 2'd3);
        push_ev(t1 + 13, K_DONE, 1'b0, 2'd0);
        repeat (13) tick();

        // start together with abort in IDLE stays IDLE.
        start = 1'b1; abort = 1'b1; we = 1'b0; bus_width = MC_BW_32;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", 32'(outs), 32'(O_IDLE));
        tick();
        check("start_abort_idle2", 32'(outs), 32'(O_IDLE));

        // Reset asserted while stalled in WAIT.
        mem_rdy = 1'b0;
        launch(t0, 1'b0, MC_BW_32, 4'd0);
        repeat (2) tick();
        check("wait_hold_outs", 32'(outs), 32'(O_RD));
        rst = 1'b0;
        tick();
        check("rst_mid_wait_outs", 32'(outs), 32'(O_IDLE));
        rst = 1'b1;
        tick();

        // mem_rdy stuck low with twait 0.
        launch(t0, 1'b0, MC_BW_32, 4'd0);
`ifdef MC_PACK_TIMEOUT_EN
        push_ev(t0 + 6, K_ERR, 1'b0, 2'd0);
        repeat (6) tick();
        check("timeout_then_idle", 32'(outs), 32'(O_IDLE));
`else
        repeat (19) tick();
        check("stall_wait_persists", 32'(outs), 32'(O_RD));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("stall_abort_idle", 32'(outs), 32'(O_IDLE));
`endif

        mem_rdy = 1'b1;
        repeat (3) tick();
        check("events_outstanding", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
